filter_decim_fifo: RTL and testbench
====================================

Name: filter_decim_fifo

Overview:
Stage directly downstream of the 1D FIR filter. It takes the filter's signed 16-bit output stream (one sample per enabled clock) and keeps every DECIM-th sample. Kept samples are buffered in a small FIFO and presented to the next consumer over a valid/ready handshake, so later stages can stall without corrupting the filter pipeline.

Parameters:
DW, 16, sample width (signed two's complement)
DECIM, 4, decimation factor, legal range 1..256
PHASE, 0, phase index in 0..DECIM-1 at which a sample is kept
DEPTH, 8, FIFO depth in samples, power of two, at least 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
d  in  DW  signed sample from filter output q
en  in  1  sample strobe; d is valid this cycle
out_data  out  DW  signed decimated sample, head of FIFO
out_valid  out  1  out_data holds a valid sample
out_ready  in  1  consumer accepts out_data this cycle
count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
overflow  out  1  sticky flag: a kept sample was dropped
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (asynchronous, takes effect immediately while reset=1):
  - phase counter = 0, FIFO pointers = 0, count = 0
  - out_valid = 0, out_data = 0, overflow = 0
  - Reset mid-operation discards all buffered samples; no partial output.
- Phase counter:
  - Wraps 0..DECIM-1, advances only on en=1 clock edges; en=0 freezes it.
  - keep = en && (phase == PHASE). With DECIM=1, every en sample is kept.
- Push: keep asserted at edge k writes d into the FIFO at that edge.
- Pop: out_valid && out_ready at an edge.
- FIFO: first-word-fall-through, registered.
  - out_valid = (count != 0). out_data is the head entry.
  - Sample pushed into an empty FIFO at edge k gives out_valid=1 after edge k. No same-cycle bypass from d to out_data.
  - Read and write pointers wrap modulo DEPTH.
- Simultaneous push and pop: both happen; count unchanged. This includes count=DEPTH, where no overflow occurs.
- Push while full with no pop: sample dropped, FIFO contents unchanged, overflow set to 1. The phase counter still advances.
- Pop while empty is impossible because out_valid=0; out_ready is ignored when empty.
- Handshake stability: while out_valid=1 and out_ready=0, out_data and out_valid hold constant.
- overflow:
  - Sticky until clr_ovf=1 at an edge.
  - If clr_ovf and a new overflow event occur in the same cycle, set wins (overflow stays 1).
- No arithmetic on data: samples pass bit-exact, sign preserved (e.g. -32768 in gives -32768 out).
- Steady state with out_ready=1 gives exactly one output per DECIM enabled inputs.

Decomposition:
- Shared package filter_pkg:
  - localparam DW = 16
  - typedef logic signed [DW-1:0] sample_t
  - FIFO count-width helper function
  - Later filter-chain blocks use the same package.
- One sub-module: sync_fifo, a parameterised single-clock FWFT FIFO with push, pop, full, empty, count and async active-high reset.
- filter_decim_fifo itself contains the phase counter, keep logic, overflow flag and FIFO instance.

Test Plan:
1. Basic decimation. DECIM=4, PHASE=0, en=1 every cycle, d=0,1,2,..., out_ready=1 -> out_data sequence 0,4,8,12,... Each out_valid goes high one cycle after its capture edge. Overflow stays 0.
2. Overflow. out_ready=0, DEPTH=8, d=0,1,2,... -> count reaches 8 after d=28 is kept; kept sample 32 is dropped and overflow=1. Then out_ready=1 -> drains exactly 0,4,...,28, count returns to 0. Pulse clr_ovf -> overflow=0.
3. Gapped strobe. en pattern 1,0,1,0,... with d=10,99,11,99,12,99,13,99,14, DECIM=2, PHASE=1 -> outputs 11,13. Values presented with en=0 are never kept.
4. Full with simultaneous push and pop. Fill to count=8, then out_ready=1 on a keep cycle -> count stays 8, overflow stays 0, FIFO order preserved.
5. Asynchronous reset mid-stream. With count=5, assert reset between clock edges -> out_valid=0 and count=0 immediately. After release, the first kept sample is the one at phase 0 of a fresh count.
6. Backpressure stability and sign. Push -32768 then 32767, hold out_ready=0 for 3 cycles -> out_data constant at -32768. Then out_ready=1 -> -32768 then 32767, bit-exact.

Source files
------------

// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Definitions shared by the blocks of the filter chain:
//   DW          - sample width of the filter datapath
//   sample_t    - signed two's complement sample type
//   fifo_cnt_w  - width needed to hold a FIFO occupancy of 0..depth
// -----------------------------------------------------------------------------
package filter_pkg;

    localparam int DW = 16;

    typedef logic signed [DW-1:0] sample_t;

    // An occupancy of 0..depth needs one bit more than the pointer width.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// o_dout whenever the FIFO is non-empty; a pop advances to the next entry.
// A push while full is accepted only when a pop happens on the same edge.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset (empties the FIFO)
//   i_push   - write i_din this edge
//   i_din    - write data
//   i_pop    - consume the head entry this edge (ignored when empty)
//   o_dout   - head entry, zero when empty
//   o_full   - occupancy equals DEPTH
//   o_empty  - occupancy is zero
//   o_count  - occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
    import filter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_rd;
    logic w_wr;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_rd    = i_pop && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_wr    = i_push && (!w_full || w_rd);

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/filter_decim_fifo.sv
// -----------------------------------------------------------------------------
// filter_decim_fifo
// Keeps every DECIM-th enabled sample from the FIR output (the one arriving at
// phase PHASE) and buffers it in a FWFT FIFO behind a valid/ready handshake.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   d          - signed sample from the filter
//   en         - d is valid this cycle
//   out_data   - signed head-of-FIFO sample
//   out_valid  - out_data holds a valid sample
//   out_ready  - consumer takes out_data this cycle
//   count      - FIFO occupancy, 0..DEPTH
//   overflow   - sticky: a kept sample was dropped because the FIFO was full
//   clr_ovf    - synchronous clear of overflow
// -----------------------------------------------------------------------------
module filter_decim_fifo #(
    parameter int DW    = filter_pkg::DW,
    parameter int DECIM = 4,
    parameter int PHASE = 0,
    parameter int DEPTH = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic signed [DW-1:0]                     d,
    input  logic                                     en,
    output logic signed [DW-1:0]                     out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [filter_pkg::fifo_cnt_w(DEPTH)-1:0] count,
    output logic                                     overflow,
    input  logic                                     clr_ovf
);

    // DECIM=1 still needs a one-bit counter so the compare is well formed.
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0] r_phase;
    logic          r_overflow;

    logic          w_keep;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_ovf_evt;
    logic [DW-1:0] w_dout;

    assign w_keep = en && (r_phase == PW'(PHASE));
    assign w_pop  = out_ready && !w_empty;
    // Full with no simultaneous pop is the only case where a kept sample is lost.
    assign w_ovf_evt = w_keep && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + 1'b1;
        end
    end

    // Setting takes priority over clearing so an event coinciding with
    // clr_ovf is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_keep),
        .i_din   (d),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign out_data  = w_dout;
    assign out_valid = !w_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_filter_decim_fifo.sv
module tb_filter_decim_fifo;
    import filter_pkg::*;

    localparam int DECIM = 4;
    localparam int PHASE = 0;
    localparam int DEPTH = 8;
    localparam int CW    = fifo_cnt_w(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    sample_t       d = '0;
    logic          en = 1'b0;
    sample_t       out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          overflow;
    logic          clr_ovf = 1'b0;

    // Second instance for the DECIM=2, PHASE=1 gapped-strobe case.
    sample_t       d2 = '0;
    logic          en2 = 1'b0;
    sample_t       out_data2;
    logic          out_valid2;
    logic          out_ready2 = 1'b0;
    logic [CW-1:0] count2;
    logic          overflow2;

    always #5 clk = ~clk;

    filter_decim_fifo #(.DW(DW), .DECIM(DECIM), .PHASE(PHASE), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .d(d), .en(en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    filter_decim_fifo #(.DW(DW), .DECIM(2), .PHASE(1), .DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .reset(reset), .d(d2), .en(en2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .count(count2),
        .overflow(overflow2), .clr_ovf(1'b0)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of kept samples, number of enabled samples seen
    // since reset, and the sticky overflow bit.
    int m_q[$];
    int m_nen = 0;
    bit m_ovf = 1'b0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_step(input string tag, input bit e, input int dv,
                              input bit rdy, input bit clr);
        bit keep;
        bit pop;
        bit drop;
        int v;
        keep = e && ((m_nen % DECIM) == PHASE);
        if (e) m_nen++;
        pop  = rdy && (m_q.size() > 0);
        drop = keep && (m_q.size() == DEPTH) && !pop;
        if (pop) begin
            v = m_q.pop_front();
            $display("%s: accepted sample %0d", tag, v);
        end
        if (keep && !drop) m_q.push_back(dv);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, out_valid, m_q.size() != 0);
        check({tag, ".count"}, count, m_q.size());
        check({tag, ".ovf"}, overflow, m_ovf);
        if (m_q.size() != 0) check({tag, ".data"}, $signed(out_data), m_q[0]);
    endtask

    task automatic cycle(input bit e, input int dv, input bit rdy, input bit clr,
                         input string tag);
        @(negedge clk);
        en = e; d = sample_t'(dv); out_ready = rdy; clr_ovf = clr;
        model_step(tag, e, dv, rdy, clr);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Reset is raised between clock edges and must act without a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; en2 = 1'b0; out_ready2 = 1'b0;
        #1;
        check({tag, ".rst_valid"}, out_valid, 0);
        check({tag, ".rst_count"}, count, 0);
        check({tag, ".rst_ovf"}, overflow, 0);
        m_q.delete();
        m_nen = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycle2(input bit e, input int dv, input bit rdy);
        @(negedge clk);
        en2 = e; d2 = sample_t'(dv); out_ready2 = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("init.valid", out_valid, 0);
        check("init.count", count, 0);
        check("init.ovf", overflow, 0);
        check("init.data", $signed(out_data), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: basic decimation with a free-running consumer
        for (int i = 0; i < 40; i++) cycle(1'b1, i, 1'b1, 1'b0, "basic");

        // 2: overflow with the consumer stalled, then drain and clear
        async_reset("ovf");
        for (int i = 0; i <= 32; i++) cycle(1'b1, i, 1'b0, 1'b0, "ovf_fill");
        check("ovf.count_full", count, 8);
        check("ovf.flag_set", overflow, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b1, 1'b0, "ovf_drain");
        check("ovf.count_empty", count, 0);
        cycle(1'b0, 0, 1'b0, 1'b1, "ovf_clr");
        check("ovf.flag_clr", overflow, 0);

        // 4: full FIFO, push and pop on the same edge
        async_reset("full");
        for (int i = 0; i < 32; i++) cycle(1'b1, i, 1'b0, 1'b0, "full_fill");
        cycle(1'b1, 32, 1'b1, 1'b0, "full_pp");
        check("full.count_kept", count, 8);
        check("full.no_ovf", overflow, 0);
        check("full.head", $signed(out_data), 4);
        for (int i = 0; i < 9; i++) cycle(1'b0, 0, 1'b1, 1'b0, "full_drain");

        // 5: asynchronous reset with five samples buffered
        async_reset("pre5");
        for (int i = 0; i < 17; i++) cycle(1'b1, 100 + i, 1'b0, 1'b0, "rst5_fill");
        check("rst5.count", count, 5);
        async_reset("rst5");
        cycle(1'b1, 555, 1'b0, 1'b0, "rst5_fresh");
        check("rst5.first_kept", $signed(out_data), 555);

        // 6: backpressure stability and extreme values
        async_reset("sign");
        cycle(1'b1, -32768, 1'b0, 1'b0, "sign");
        for (int i = 0; i < 3; i++) cycle(1'b1, 7, 1'b0, 1'b0, "sign");
        cycle(1'b1, 32767, 1'b0, 1'b0, "sign");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 0, 1'b0, 1'b0, "sign_hold");
            check("sign.hold_data", $signed(out_data), -32768);
        end
        cycle(1'b0, 0, 1'b1, 1'b0, "sign_pop");
        check("sign.second", $signed(out_data), 32767);
        cycle(1'b0, 0, 1'b1, 1'b0, "sign_pop");

        // 3: gapped strobe on the DECIM=2, PHASE=1 instance
        async_reset("gap");
        for (int i = 0; i < 9; i++)
            cycle2((i % 2) == 0, ((i % 2) == 0) ? 10 + i / 2 : 99, 1'b0);
        check("gap.count", count2, 2);
        check("gap.first", $signed(out_data2), 11);
        cycle2(1'b0, 0, 1'b1);
        $display("gap: accepted sample 11");
        check("gap.second", $signed(out_data2), 13);
        cycle2(1'b0, 0, 1'b1);
        $display("gap: accepted sample 13");
        check("gap.empty", out_valid2, 0);

        // Randomized traffic with alternating consumer pressure
        async_reset("rand");
        for (int i = 0; i < 1500; i++) begin
            bit e;
            bit rdy;
            bit clr;
            int dv;
            e   = ($urandom_range(0, 3) != 0);
            rdy = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            dv  = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
            else cycle(e, dv, rdy, clr, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
